// File: rtl/gf233_mul_arbiter.sv
// Round-robin front end that time-shares one GF(2^233) multiplier between NREQ requesters.
// Operands are held on mul_a/mul_b for MUL_LAT cycles and the product is returned over a valid/ready handshake.
module gf233_mul_arbiter #(
    parameter int NREQ    = 2,
    parameter int W       = 233,
    parameter int MUL_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [W-1:0]      rsp_data,
    output logic              mul_start,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    input  logic [W-1:0]      mul_r,
    output logic              busy
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MUL_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    mul_a_q, mul_a_d;
    logic [W-1:0]    mul_b_q, mul_b_d;
    logic [W-1:0]    rsp_data_q, rsp_data_d;
    logic            mul_start_q, mul_start_d;

    logic [W-1:0]    a_arr [NREQ];
    logic [W-1:0]    b_arr [NREQ];
    logic            grant_found;
    logic [GW-1:0]   grant_idx;
    logic [GW:0]     cand_full;
    logic [GW-1:0]   cand;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lanes
        assign a_arr[gi]     = req_a[gi*W +: W];
        assign b_arr[gi]     = req_b[gi*W +: W];
        assign req_ready[gi] = rst_n && (state_q == S_IDLE) && grant_found && (grant_idx == GW'(gi));
        assign rsp_valid[gi] = (state_q == S_RESP) && (last_grant_q == GW'(gi));
    end

    // Scan from farthest to nearest so the requester closest after last_grant wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_full   = '0;
        cand        = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand_full = {1'b0, last_grant_q} + (GW+1)'(k);
            if (cand_full >= (GW+1)'(NREQ)) begin
                cand_full = cand_full - (GW+1)'(NREQ);
            end
            cand = cand_full[GW-1:0];
            if (req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        rsp_data_d   = rsp_data_q;
        mul_start_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    mul_a_d      = a_arr[grant_idx];
                    mul_b_d      = b_arr[grant_idx];
                    last_grant_d = grant_idx;
                    cnt_d        = CW'(MUL_LAT);
                    mul_start_d  = 1'b1;
                    state_d      = S_BUSY;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    rsp_data_d = mul_r;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready[last_grant_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= GW'(NREQ - 1);
            cnt_q        <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            rsp_data_q   <= '0;
            mul_start_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            rsp_data_q   <= rsp_data_d;
            mul_start_q  <= mul_start_d;
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_data  = rsp_data_q;
    assign mul_start = mul_start_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_gf233_mul_arbiter.sv
// Directed bench for gf233_mul_arbiter: a driver pushes expected results at accept time,
// a monitor pops and checks them whenever a response is presented.
module tb_gf233_mul_arbiter;

    localparam int NREQ    = 2;
    localparam int W       = 233;
    localparam int MUL_LAT = 2;
    localparam logic [W-1:0] POLY_LO = (W'(1) << 74) | W'(1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [W-1:0]      rsp_data;
    logic              mul_start;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic [W-1:0]      mul_r;
    logic              busy;

    always #5 clk = ~clk;

    gf233_mul_arbiter #(.NREQ(NREQ), .W(W), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_r(mul_r), .busy(busy)
    );

    // Stand-in for the shared multiplier: shift-and-add with reduction by x^233 + x^74 + 1.
    function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic msb;
        r = '0;
        for (int i = W - 1; i >= 0; i--) begin
            msb = r[W-1];
            r = r << 1;
            if (msb) r = r ^ POLY_LO;
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    assign mul_r = gf_mul(mul_a, mul_b);

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } op_t;

    op_t          pend0[$];
    op_t          pend1[$];
    int           exp_grant[$];
    int           sb_who[$];
    logic [W-1:0] sb_exp[$];

    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           acc_cyc = 0;
    int           hs_cyc = 0;
    logic [W-1:0] cur_a = '0;
    logic [NREQ-1:0] en = '0;
    logic [NREQ-1:0] acc_flag = '0;
    logic [NREQ-1:0] prev_rv = '0;
    logic         expect_quick = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready", W'(req_ready), '0);
        chk("rst_rsp_valid", W'(rsp_valid), '0);
        chk("rst_rsp_data", rsp_data, '0);
        chk("rst_mul_a", mul_a, '0);
        chk("rst_mul_b", mul_b, '0);
        chk("rst_mul_start", W'(mul_start), '0);
        chk("rst_busy", W'(busy), '0);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while ((pend0.size() != 0 || pend1.size() != 0 || sb_who.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) fail(name);
    endtask

    initial forever @(posedge clk) cyc++;

    // Driver: retire ops accepted at the previous edge, re-drive, then detect accepts for the coming edge.
    initial begin
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        forever begin
            @(negedge clk);
            if (acc_flag[0] && pend0.size() != 0) void'(pend0.pop_front());
            if (acc_flag[1] && pend1.size() != 0) void'(pend1.pop_front());
            acc_flag = '0;
            req_valid[0] = en[0] && (pend0.size() != 0);
            req_valid[1] = en[1] && (pend1.size() != 0);
            req_a[0*W +: W] = (pend0.size() != 0) ? pend0[0].a : '1;
            req_b[0*W +: W] = (pend0.size() != 0) ? pend0[0].b : '1;
            req_a[1*W +: W] = (pend1.size() != 0) ? pend1[0].a : '1;
            req_b[1*W +: W] = (pend1.size() != 0) ? pend1[0].b : '1;
            #1;
            chk("ready_onehot", W'($countones(req_ready) <= 1), W'(1));
            for (int i = 0; i < NREQ; i++) begin
                if (rst_n && req_valid[i] && req_ready[i]) begin
                    op_t op;
                    op = (i == 0) ? pend0[0] : pend1[0];
                    acc_flag[i] = 1'b1;
                    if (exp_grant.size() == 0) fail("grant_unexpected");
                    else chk("grant_order", W'(i), W'(exp_grant.pop_front()));
                    sb_who.push_back(i);
                    sb_exp.push_back(op.exp);
                    cur_a = op.a;
                    acc_cyc = cyc;
                    if (expect_quick) begin
                        chk("accept_after_hs", W'(cyc), W'(hs_cyc + 1));
                        expect_quick = 1'b0;
                    end
                    $display("accept  req%0d cyc=%0d a=%0h b=%0h", i, cyc, op.a, op.b);
                end
            end
        end
    end

    // Monitor: compare every presented response against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mul_start) chk("mul_start_lat", W'(cyc), W'(acc_cyc + 1));
            if (busy) begin
                chk("mul_a_hold", mul_a, cur_a);
                chk("req_ready_busy", W'(req_ready), '0);
            end
            if (rsp_valid != '0) begin
                if (sb_who.size() == 0) begin
                    fail("rsp_unexpected");
                end else begin
                    chk("rsp_who", W'(rsp_valid), W'(1) << sb_who[0]);
                    chk("rsp_data", rsp_data, sb_exp[0]);
                    if (prev_rv == '0) chk("rsp_latency", W'(cyc), W'(acc_cyc + MUL_LAT + 1));
                    if ((rsp_valid & rsp_ready) != '0) begin
                        $display("respond req%0d cyc=%0d data=%0h", sb_who[0], cyc, rsp_data);
                        void'(sb_who.pop_front());
                        void'(sb_exp.pop_front());
                        hs_cyc = cyc;
                    end
                end
            end
            prev_rv = rsp_valid;
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        rsp_ready = '1;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b1;
        en = '1;

        // single op: (x)(x+1) = x^2+x
        pend0.push_back('{a: W'(2), b: W'(3), exp: W'(6)});
        exp_grant.push_back(0);
        wait_done("single_timeout", 50);

        // reduction: x^232 * x = x^74 + 1
        pend1.push_back('{a: W'(1) << 232, b: W'(2), exp: POLY_LO});
        exp_grant.push_back(1);
        wait_done("reduce_timeout", 50);

        // round robin with both requesters valid
        en = '0;
        pend0.push_back('{a: W'(5), b: W'(3), exp: W'('h0F)});
        pend0.push_back('{a: W'(6), b: W'(6), exp: W'('h14)});
        pend1.push_back('{a: W'(7), b: W'(7), exp: W'('h15)});
        pend1.push_back('{a: W'(3), b: W'(3), exp: W'(5)});
        exp_grant.push_back(0); exp_grant.push_back(1);
        exp_grant.push_back(0); exp_grant.push_back(1);
        en = '1;
        wait_done("rr_timeout", 100);

        // back-pressure on requester 0 while requester 1 waits
        en = '0;
        rsp_ready = 2'b10;
        pend0.push_back('{a: W'('h11), b: W'(3), exp: W'('h33)});
        pend1.push_back('{a: W'(2), b: W'('h80), exp: W'('h100)});
        exp_grant.push_back(0); exp_grant.push_back(1);
        en = '1;
        n = 0;
        while (!rsp_valid[0] && n < 20) begin @(negedge clk); n++; end
        if (!rsp_valid[0]) fail("bp_rsp_timeout");
        repeat (10) @(negedge clk);
        expect_quick = 1'b1;
        rsp_ready = 2'b11;
        wait_done("bp_timeout", 50);
        if (expect_quick) fail("bp_no_accept");
        expect_quick = 1'b0;

        // reset during the second BUSY cycle
        pend0.push_back('{a: W'(5), b: W'(5), exp: W'('h11)});
        exp_grant.push_back(0);
        n = 0;
        while (!mul_start && n < 20) begin @(negedge clk); n++; end
        if (!mul_start) fail("rst_start_timeout");
        @(negedge clk);
        rst_n = 1'b0;
        pend0.delete(); pend1.delete(); exp_grant.delete();
        sb_who.delete(); sb_exp.delete();
        @(negedge clk);
        chk_reset_outputs();
        pend0.push_back('{a: W'(9), b: W'(3), exp: W'('h1B)});
        pend1.push_back('{a: W'('hA), b: W'(3), exp: W'('h1E)});
        exp_grant.push_back(0); exp_grant.push_back(1);
        @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b1;
        wait_done("post_rst_timeout", 100);

        // operand stability: driver replaces req_a with all-ones right after accept
        pend0.push_back('{a: W'(1), b: W'('h1ABC), exp: W'('h1ABC)});
        exp_grant.push_back(0);
        wait_done("stable_timeout", 50);
        repeat (3) @(negedge clk);
        chk("sb_drained", W'(sb_who.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
